// File: rtl/gb80_pkg.sv
// Shared types and constants for the gb80 memory arbiter / OAM DMA slice.
package gb80_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DMA_RD = 2'd1,
    ST_DMA_WR = 2'd2
  } gb80_state_e;

  localparam logic [15:0] GB80_DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] GB80_OAM_BASE     = 16'hFE00;
  localparam int          GB80_OAM_LEN      = 160;

  // Index of the final byte; transfer lengths of 1..256 fit an 8-bit idx.
  localparam logic [7:0]  GB80_IDX_LAST     = 8'(GB80_OAM_LEN - 1);

  // Bus request driven by the DMA engine while it owns memory.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } gb80_bus_req_t;

endpackage

// File: rtl/gb80_mem_arbiter_if.sv
// Processor + memory bus bundle for gb80_mem_arbiter.
// slave: arbiter view; master: processor/memory side view.
interface gb80_mem_arbiter_if;
  logic        i_cpu_rd;
  logic        i_cpu_wr;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_data;
  logic [7:0]  o_cpu_data;
  logic        o_cpu_wait;
  logic [7:0]  i_mem_data;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic        o_dma_busy;

  modport slave (
    input  i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_data, i_mem_data,
    output o_cpu_data, o_cpu_wait, o_mem_addr, o_mem_data, o_mem_rd, o_mem_wr,
           o_dma_busy
  );

  modport master (
    output i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_data, i_mem_data,
    input  o_cpu_data, o_cpu_wait, o_mem_addr, o_mem_data, o_mem_rd, o_mem_wr,
           o_dma_busy
  );
endinterface

// File: rtl/gb80_dma_engine.sv
// OAM DMA sequencer: alternates a read of {src,idx} with a write to
// OAM_BASE+idx until GB80_OAM_LEN bytes are copied. A start always wins,
// restarting from idx 0 with the new source page.
// Optional: GB80_DMA_READBACK_EN makes the source register readable.
module gb80_dma_engine
  import gb80_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          start,
  input  logic [7:0]    start_src,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic [7:0]    reg_rdata,
  output gb80_bus_req_t req
);

  gb80_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dbuf_q, dbuf_d;

  // State, index, source page and data buffer registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dbuf_q  <= dbuf_d;
    end
  end

  // Next state and DMA bus request; a start overrides any in-flight step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    dbuf_d  = dbuf_q;
    req     = '0;
    unique case (state_q)
      ST_IDLE: ;
      ST_DMA_RD: begin
        req.rd  = 1'b1;
        req.addr = {src_q, idx_q};   // low byte is idx, no carry into page
        dbuf_d  = mem_rdata;
        state_d = ST_DMA_WR;
      end
      ST_DMA_WR: begin
        req.wr   = 1'b1;
        req.addr = GB80_OAM_BASE + {8'h00, idx_q};
        req.data = dbuf_q;
        idx_d    = idx_q + 8'd1;
        state_d  = (idx_q == GB80_IDX_LAST) ? ST_IDLE : ST_DMA_RD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      src_d   = start_src;
      idx_d   = '0;
      state_d = ST_DMA_RD;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef GB80_DMA_READBACK_EN
  assign reg_rdata = src_q;
`else
  assign reg_rdata = 8'hFF;
`endif

endmodule

// File: rtl/gb80_mem_arbiter.sv
// Memory-bus arbiter between the processor and system memory. Decodes the
// DMA register, passes processor traffic straight through when idle and
// stalls it while the OAM DMA engine owns the bus.
// Optional: GB80_DMA_READBACK_EN (read of the DMA register returns src).
module gb80_mem_arbiter
  import gb80_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  gb80_mem_arbiter_if.slave    bus
);

  logic          reg_hit, start, reg_rd, cpu_acc;
  logic          busy;
  logic [7:0]    reg_rdata;
  gb80_bus_req_t dma_req;

  assign reg_hit = (bus.i_cpu_addr == GB80_DMA_REG_ADDR);
  assign start   = bus.i_cpu_wr & reg_hit;
  assign reg_rd  = bus.i_cpu_rd & reg_hit;
  // Any processor access that must reach real memory.
  assign cpu_acc = (bus.i_cpu_rd | bus.i_cpu_wr) & ~reg_hit;

  gb80_dma_engine u_dma (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .start     (start),
    .start_src (bus.i_cpu_data),
    .mem_rdata (bus.i_mem_data),
    .busy      (busy),
    .reg_rdata (reg_rdata),
    .req       (dma_req)
  );

  // Bus ownership mux: DMA while busy, otherwise zero-latency passthrough.
  always_comb begin
    bus.o_mem_addr = '0;
    bus.o_mem_data = '0;
    bus.o_mem_rd   = 1'b0;
    bus.o_mem_wr   = 1'b0;
    bus.o_cpu_data = '0;
    bus.o_cpu_wait = 1'b0;
    if (busy) begin
      bus.o_mem_addr = dma_req.addr;
      bus.o_mem_data = dma_req.data;
      bus.o_mem_rd   = dma_req.rd;
      bus.o_mem_wr   = dma_req.wr;
      bus.o_cpu_wait = cpu_acc;
    end else if (cpu_acc) begin
      bus.o_mem_addr = bus.i_cpu_addr;
      bus.o_mem_data = bus.i_cpu_data;
      bus.o_mem_rd   = bus.i_cpu_rd;
      bus.o_mem_wr   = bus.i_cpu_wr;
      bus.o_cpu_data = bus.i_mem_data;
    end
    // The DMA register is answered locally in every state.
    if (reg_rd) bus.o_cpu_data = reg_rdata;
  end

  assign bus.o_dma_busy = busy;

endmodule

// File: tb/tb_gb80_mem_arbiter.sv
// Self-checking bench for gb80_mem_arbiter: passthrough, full OAM DMA,
// stalled access, restart, mid-transfer reset and DMA register readback.
module tb_gb80_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gb80_mem_arbiter_if bus();
  gb80_mem_arbiter dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  // Memory model: combinational, data = low address byte ^ 3C, or an override.
  logic       ovr_en;
  logic [7:0] ovr_val;
  assign bus.i_mem_data = ovr_en ? ovr_val :
                          (bus.o_mem_rd ? (bus.o_mem_addr[7:0] ^ 8'h3C) : 8'h00);

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];

  int busy_cyc, ff46_wr, xfer_done;

`ifdef GB80_DMA_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: a transfer is a flat list of (read {src,k}, write FE00+k) pairs.
  function automatic void model(input logic [7:0] src, input int npairs, input bit extra_rd);
    for (int k = 0; k < npairs; k++) begin
      logic [7:0] b;
      b = 8'(k) ^ 8'h3C;
      exp_q.push_back(ev_t'{1'b0, {src, 8'(k)}, b});
      exp_q.push_back(ev_t'{1'b1, 16'hFE00 + 16'(k), b});
    end
    if (extra_rd) exp_q.push_back(ev_t'{1'b0, {src, 8'(npairs)}, 8'(npairs) ^ 8'h3C});
  endfunction

  task automatic cmp_events(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_content"}, bad, 0);
  endtask

  task automatic start_dma(input logic [7:0] src);
    bus.i_cpu_rd = 1'b0;
    bus.i_cpu_wr = 1'b1;
    bus.i_cpu_addr = 16'hFF46;
    bus.i_cpu_data = src;
    @(negedge clk);
    chk("start_not_fwd", {bus.o_mem_wr, bus.o_mem_rd, bus.o_cpu_wait}, 3'b000);
  endtask

  // Follows one transfer from the start edge; cycle 0 is the first DMA_RD.
  task automatic run_xfer(input int stall_at, input int restart_at,
                          input logic [7:0] new_src, input int reset_at);
    int  cyc;
    bit  seen, stall;
    int  stall_bad;
    cyc = 0; seen = 0; stall = 0; stall_bad = 0;
    busy_cyc = 0; ff46_wr = 0; xfer_done = 0;
    got_q.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      @(posedge clk); #1;
      bus.i_cpu_wr = 1'b0;
      if (cyc == stall_at) begin
        bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'h8000; stall = 1;
      end
      if (cyc == restart_at) begin
        bus.i_cpu_wr = 1'b1; bus.i_cpu_addr = 16'hFF46; bus.i_cpu_data = new_src;
      end
      if (cyc == reset_at) rst = 1'b1;
      @(negedge clk);
      if (bus.o_mem_wr && bus.o_mem_addr == 16'hFF46) ff46_wr++;
      if (bus.o_dma_busy) begin
        busy_cyc++;
        seen = 1;
        if (bus.o_mem_rd || bus.o_mem_wr)
          got_q.push_back(ev_t'{bus.o_mem_wr, bus.o_mem_addr,
                                bus.o_mem_wr ? bus.o_mem_data : bus.i_mem_data});
        if (stall && (bus.o_cpu_wait !== 1'b1 || bus.o_cpu_data !== 8'h00)) stall_bad++;
      end else if (seen) begin
        if (stall) begin
          chk("stall_held", stall_bad, 0);
          chk("stall_release_wait", bus.o_cpu_wait, 1'b0);
          chk("stall_release_bus", {bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr}, {2'b10, 16'h8000});
          chk("stall_release_data", bus.o_cpu_data, 8'h3C);
        end
        xfer_done = 1;
        break;
      end
      cyc++;
    end
    chk("xfer_completed", xfer_done, 1);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    logic [7:0]  s;
    int          stray;

    rst = 1'b1;
    bus.i_cpu_rd = 1'b0; bus.i_cpu_wr = 1'b0;
    bus.i_cpu_addr = '0; bus.i_cpu_data = '0;
    ovr_en = 1'b0; ovr_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_strobes", {bus.o_mem_rd, bus.o_mem_wr}, 2'b00);
    chk("reset_mem_addr", bus.o_mem_addr, 16'h0000);
    chk("reset_mem_data", bus.o_mem_data, 8'h00);
    chk("reset_cpu", {bus.o_cpu_data, bus.o_cpu_wait, bus.o_dma_busy}, 10'h000);
    @(posedge clk); #1 rst = 1'b0;

    // Passthrough read with a fixed memory answer.
    ovr_en = 1'b1; ovr_val = 8'h5A;
    bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'hC000;
    @(negedge clk);
    chk("pt_c000_bus", {bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr}, {2'b10, 16'hC000});
    chk("pt_c000_data", bus.o_cpu_data, 8'h5A);
    chk("pt_c000_wait", bus.o_cpu_wait, 1'b0);
    @(posedge clk); #1;
    bus.i_cpu_rd = 1'b0; ovr_en = 1'b0;

    // Randomized passthrough traffic.
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      if (a == 16'hFF46) a = 16'hFF47;
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      bus.i_cpu_addr = a; bus.i_cpu_data = d;
      bus.i_cpu_rd = r; bus.i_cpu_wr = ~r;
      @(negedge clk);
      chk("pt_rand_bus", {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_rd, bus.o_mem_wr, bus.o_cpu_wait},
          {a, d, r, ~r, 1'b0});
      chk("pt_rand_data", bus.o_cpu_data, r ? (a[7:0] ^ 8'h3C) : 8'h00);
      @(posedge clk); #1;
    end
    bus.i_cpu_rd = 1'b0; bus.i_cpu_wr = 1'b0;
    @(negedge clk);
    chk("idle_quiet", {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_rd, bus.o_mem_wr}, 26'h0);

    // Full transfer from page C1 with a processor read stalled mid-way.
    @(posedge clk); #1;
    start_dma(8'hC1);
    run_xfer(101, -1, 8'h00, -1);
    exp_q.delete();
    model(8'hC1, 160, 1'b0);
    cmp_events("xfer_c1");
    chk("xfer_c1_busy", busy_cyc, 320);
    chk("xfer_c1_no_ff46_wr", ff46_wr, 0);
    @(posedge clk); #1;
    bus.i_cpu_rd = 1'b0;

    // DMA register readback.
    bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("readback", bus.o_cpu_data, RB ? 8'hC1 : 8'hFF);
    chk("readback_local", {bus.o_cpu_wait, bus.o_mem_rd, bus.o_mem_wr}, 3'b000);
    @(posedge clk); #1;
    bus.i_cpu_rd = 1'b0;

    // Restart to page C2 while reading idx 50 of a random page.
    s = 8'($urandom);
    start_dma(s);
    run_xfer(-1, 100, 8'hC2, -1);
    exp_q.delete();
    model(s, 50, 1'b1);
    model(8'hC2, 160, 1'b0);
    cmp_events("restart");
    chk("restart_busy", busy_cyc, 421);
    @(posedge clk); #1;

    // Asynchronous reset at idx 80 of a random page.
    s = 8'($urandom);
    start_dma(s);
    run_xfer(-1, -1, 8'h00, 160);
    exp_q.delete();
    model(s, 80, 1'b0);
    cmp_events("reset_abort");
    chk("reset_abort_busy", busy_cyc, 160);
    chk("reset_abort_outs", {bus.o_mem_addr, bus.o_mem_data, bus.o_mem_rd, bus.o_mem_wr, bus.o_dma_busy},
        27'h0);
    @(posedge clk); #1 rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_mem_rd || bus.o_mem_wr || bus.o_dma_busy) stray++;
    end
    chk("reset_no_resume", stray, 0);
    @(posedge clk); #1;
    bus.i_cpu_rd = 1'b1; bus.i_cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("readback_after_reset", bus.o_cpu_data, RB ? 8'h00 : 8'hFF);
    @(posedge clk); #1;
    bus.i_cpu_rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gb80_mem_arbiter.md
# gb80_mem_arbiter

Memory-bus arbiter and OAM DMA sequencer between `gb80_processor` and system memory. It owns the single 16-bit address / 8-bit data memory port. It intercepts processor writes to the DMA register and then copies `DMA_LENGTH` bytes from `{src,8'h00}` to `OAM_BASE`. While a copy is running, all other processor accesses are stalled.

## Interface
- `DMA_REG_ADDR`, 16'hFF46, processor address of the DMA source register.
- `OAM_BASE`, 16'hFE00, first destination address.
- `DMA_LENGTH`, 160, bytes per transfer (1..256).
- `i_clk` input 1: system clock; all state updates on the rising edge.
- `i_reset` input 1: reset, asynchronous and active-high.
- `i_cpu_rd` input 1: processor read strobe.
- `i_cpu_wr` input 1: processor write strobe.
- `i_cpu_addr` input 16: processor address.
- `i_cpu_data` input 8: processor write data.
- `o_cpu_data` output 8: read data returned to the processor.
- `o_cpu_wait` output 1: stall; the processor holds its strobes, address and data while this is high.
- `i_mem_data` input 8: memory read data, combinational (valid in the same cycle as `o_mem_rd`).
- `o_mem_addr` output 16: memory address.
- `o_mem_data` output 8: memory write data.
- `o_mem_rd` output 1: memory read strobe.
- `o_mem_wr` output 1: memory write strobe.
- `o_dma_busy` output 1: a DMA transfer is in progress.

## Operation
- FSM states:
  - IDLE: processor owns the bus.
  - DMA_RD: drive `o_mem_addr={src,idx}`, `o_mem_rd=1`; latch `i_mem_data` into `dbuf`.
  - DMA_WR: drive `o_mem_addr=OAM_BASE+idx`, `o_mem_data=dbuf`, `o_mem_wr=1`; `idx` increments.
- Transitions:
  - DMA_RD always goes to DMA_WR.
  - DMA_WR goes to IDLE when `idx==DMA_LENGTH-1`; otherwise it goes to DMA_RD.
- `idx` is 8 bits and is cleared on every start. Source low byte equals `idx`; there is no carry into the high byte. Destination is a 16-bit add.
- Start: processor write with `i_cpu_addr==DMA_REG_ADDR`, in any state.
  - `src <= i_cpu_data`, `idx <= 0`, next state DMA_RD.
  - The write is never forwarded to memory and is never stalled.
  - A start during a transfer restarts it. A start in the same cycle as the final DMA_WR wins, so the next state is DMA_RD.
- DMA register read: processor read of `DMA_REG_ADDR` is answered locally, never stalled and never forwarded (value per Configuration).
- IDLE, any other processor access: passthrough.
  - `o_mem_addr/o_mem_data/o_mem_rd/o_mem_wr` follow the `i_cpu_*` signals combinationally.
  - `o_cpu_data=i_mem_data`.
  - `o_cpu_wait=0`.
- DMA_RD/DMA_WR, any other processor access: `o_cpu_wait=1` while the strobe is held. `o_cpu_data=8'h00`. The processor never drives memory.
- `o_dma_busy` is high in DMA_RD and DMA_WR.
- With no processor strobe in IDLE, all memory outputs are 0.

## Timing
- Reset (asynchronous, mid-transfer included):
  - IDLE, `src=8'h00`, `idx=0`, `dbuf=8'h00`.
  - All outputs 0 except passthrough paths, which are combinational from the `i_cpu_*` inputs.
  - An aborted transfer is not resumed.
- Start latency: the start write occurs at edge N; the first DMA_RD is in cycle N+1.
- A transfer takes exactly `2*DMA_LENGTH` cycles (320 by default). The cycle after the final DMA_WR is IDLE.
- A stalled processor access completes in the first IDLE cycle. `o_cpu_wait` falls in that cycle.
- Passthrough adds 0 cycles of latency.

## Configuration
- `GB80_DMA_READBACK_EN`:
  - Defined: a read of `DMA_REG_ADDR` returns `src`.
  - Undefined: it returns 8'hFF and `src` is write-only.
- Everything else is identical in both builds.

## Structure
- Shared package `gb80_pkg`:
  - state enum (IDLE, DMA_RD, DMA_WR);
  - address constants `GB80_DMA_REG_ADDR` and `GB80_OAM_BASE`;
  - `GB80_OAM_LEN`.
- Sub-module `gb80_dma_engine`: holds the FSM, `idx`, `src` and `dbuf`, and outputs the DMA bus request.
- The top level holds the address decode and the passthrough/stall muxing.

## Test plan
- Reset, then processor read 16'hC000 with memory returning 8'h5A: `o_mem_rd=1`, `o_cpu_data=8'h5A`, `o_cpu_wait=0` in the same cycle.
- Write 8'hC1 to FF46; memory model returns `addr[7:0]^8'h3C`:
  - 160 write pairs, FE00..FE9F, each carrying the expected byte;
  - busy for exactly 320 cycles;
  - no memory write to FF46.
- Processor read 16'h8000 issued mid-transfer: `o_cpu_wait=1` until busy drops, then the read completes with memory data in the first IDLE cycle.
- Rewrite FF46 with 8'hC2 at idx 50: the next cycle is DMA_RD at C200, and 160 full pairs follow.
- Assert `i_reset` at idx 80: outputs go to 0 immediately, busy=0, and no further DMA strobes appear.
- Read FF46 after writing 8'hC1: returns 8'hC1 with `GB80_DMA_READBACK_EN`, 8'hFF without; no stall in either case.
